// File: rtl/stream_cipher_sequencer_if.sv
// Host-side pin bundle for the stream cipher sequencer.
// The host drives write/ack strobes and reads back the held result and status flags.
interface stream_cipher_sequencer_if;
  logic       host_wr;
  logic       host_key_mode;
  logic [7:0] host_din;
  logic       host_ack;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       err_timeout;
  logic       key_valid;

  modport master (
    output host_wr, host_key_mode, host_din, host_ack,
    input  dout, dout_valid, busy, err_timeout, key_valid
  );

  modport slave (
    input  host_wr, host_key_mode, host_din, host_ack,
    output dout, dout_valid, busy, err_timeout, key_valid
  );
endinterface

// File: rtl/stream_cipher_sequencer.sv
// Control FSM for the byte-wide stream cipher engine: assembles the key,
// fires key-load and encryption strobes, holds results until acknowledged
// and flags engine timeouts.
//
// state | meaning
// IDLE  | waiting for a host key byte or data byte
// KLOAD | full key assembled, eng_key_load pulsing
// ENC   | encryption in flight, waiting for eng_done or timeout
// HOLD  | result held on dout until host_ack
// ERR   | engine timed out, waiting for host_ack
module stream_cipher_sequencer #(
  parameter int KEY_BYTES = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   nrst,
  stream_cipher_sequencer_if.slave host,
  output logic [8*KEY_BYTES-1:0] eng_key,
  output logic                   eng_key_load,
  output logic [7:0]             eng_din,
  output logic                   eng_start,
  input  logic [7:0]             eng_dout,
  input  logic                   eng_done,
  output logic [2:0]             state
);

  localparam int KCW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_BYTES - 1);
  localparam logic [7:0]     TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_ENC   = 3'd2,
    S_HOLD  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [KCW-1:0]         key_cnt;
  logic [7:0]             tmo_cnt;
  logic [7:0]             dout_q;
  logic                   dout_valid_q;
  logic                   busy_q;
  logic                   err_q;
  logic                   key_valid_q;
  logic [8*KEY_BYTES-1:0] key_shift;

  logic wr_key, wr_data, key_last, tmo_exp;

  assign wr_key   = host.host_wr & host.host_key_mode;
  assign wr_data  = host.host_wr & ~host.host_key_mode;
  assign key_last = (key_cnt == KEY_LAST);
  assign tmo_exp  = (tmo_cnt == TMO_LAST);

  // Earlier key bytes shift toward the MSBs so the first byte lands on top.
  if (KEY_BYTES == 1) begin : g_key_one
    assign key_shift = host.host_din;
  end else begin : g_key_many
    assign key_shift = {eng_key[8*KEY_BYTES-9:0], host.host_din};
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (wr_key && key_last)          state_d = S_KLOAD;
        else if (wr_data && key_valid_q) state_d = S_ENC;
      end
      S_KLOAD: state_d = S_IDLE;
      S_ENC: begin
        if (eng_done)     state_d = S_HOLD;
        else if (tmo_exp) state_d = S_ERR;
      end
      S_HOLD:  if (host.host_ack) state_d = S_IDLE;
      S_ERR:   if (host.host_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, key/timeout counters and result capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      eng_key      <= '0;
      eng_din      <= '0;
      eng_start    <= 1'b0;
      eng_key_load <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_cnt      <= '0;
      tmo_cnt      <= '0;
    end else begin
      // Strobes are derived from the upcoming transition so they line up
      // with the first cycle of the new state.
      eng_start    <= (state_d == S_ENC) && (state_q != S_ENC);
      eng_key_load <= (state_d == S_KLOAD);
      busy_q       <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (wr_key) begin
            eng_key     <= key_shift;
            key_valid_q <= 1'b0;
            key_cnt     <= key_last ? '0 : key_cnt + 1'b1;
          end else if (wr_data && key_valid_q) begin
            eng_din <= host.host_din;
            tmo_cnt <= '0;
          end
        end
        S_KLOAD: key_valid_q <= 1'b1;
        S_ENC: begin
          if (eng_done) begin
            dout_q       <= eng_dout;
            dout_valid_q <= 1'b1;
          end else if (tmo_exp) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_HOLD:  if (host.host_ack) dout_valid_q <= 1'b0;
        S_ERR:   if (host.host_ack) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign state            = state_q;
  assign host.dout        = dout_q;
  assign host.dout_valid  = dout_valid_q;
  assign host.busy        = busy_q;
  assign host.err_timeout = err_q;
  assign host.key_valid   = key_valid_q;

endmodule

// File: doc/stream_cipher_sequencer.md
# stream_cipher_sequencer

Control FSM for the byte-wide stream cipher datapath. It collects a multi-byte key from the host, loads it into the keystream/encryption engine, and issues one encryption per host data byte. It captures the engine's single-cycle result pulse and holds it for the host until an explicit acknowledge. It also reports engine timeouts. It sits between the host-facing pin interface and the encryption engine, and is the only block that drives the engine's control strobes.

## Interface
Parameters:
- KEY_BYTES, 4, number of key bytes per key load (≥1)
- TIMEOUT, 255, max cycles in ENC waiting for eng_done (≥1, fits 8 bits)

Ports:
- clk  input  1  system clock, all logic on posedge
- nrst  input  1  reset, asynchronous, active-low
- host_wr  input  1  one-cycle write strobe from host interface
- host_key_mode  input  1  qualifies host_wr: 1 = key byte, 0 = plaintext byte
- host_din  input  8  host byte, sampled when host_wr=1
- host_ack  input  1  host has read dout / clears error
- eng_key  output  8*KEY_BYTES  assembled key to engine
- eng_key_load  output  1  one-cycle key load strobe
- eng_din  output  8  plaintext byte to engine
- eng_start  output  1  one-cycle encryption start strobe
- eng_dout  input  8  engine result
- eng_done  input  1  one-cycle result-valid pulse
- dout  output  8  held result to output mux
- dout_valid  output  1  dout holds an unread result
- busy  output  1  state != IDLE
- err_timeout  output  1  engine timed out; sticky until ack
- key_valid  output  1  full key loaded since reset
- state  output  3  current state encoding (debug)

## Operation
- States: IDLE=0, KLOAD=1, ENC=2, HOLD=3, ERR=4. Other encodings are unreachable; if entered, the FSM goes to IDLE.
- Reset values: state IDLE; eng_key, eng_din, dout = 0; all strobes, dout_valid, err_timeout, key_valid, busy = 0; key_cnt and tmo_cnt = 0.
- IDLE, host_wr & host_key_mode:
  - eng_key <= {eng_key[8*KEY_BYTES-9:0], host_din}, so the first byte ends up in the MSBs.
  - key_valid <= 0.
  - key_cnt increments.
  - If key_cnt was KEY_BYTES-1: key_cnt <= 0 and go to KLOAD.
- KLOAD: eng_key_load=1 for exactly one cycle, key_valid <= 1, go to IDLE.
- IDLE, host_wr & !host_key_mode & key_valid: eng_din <= host_din, tmo_cnt <= 0, go to ENC.
- IDLE, host_wr & !host_key_mode & !key_valid: write ignored, no state change.
- ENC:
  - eng_start=1 on the first ENC cycle only.
  - If eng_done: dout <= eng_dout, dout_valid <= 1, go to HOLD.
  - Otherwise tmo_cnt increments. When tmo_cnt reaches TIMEOUT-1 without eng_done: err_timeout <= 1, go to ERR.
  - eng_done in the same cycle as expiry wins: the result is captured and no error is raised.
- HOLD: dout_valid stays 1 and dout stays stable. On host_ack: dout_valid <= 0, go to IDLE. dout keeps its last value.
- ERR: on host_ack, err_timeout <= 0 and go to IDLE. key_valid is preserved.
- host_wr outside IDLE is ignored, including a write in the same cycle as the host_ack that leaves HOLD/ERR.
- eng_done outside ENC is ignored.
- A partial key (fewer than KEY_BYTES bytes) leaves key_valid=0 until completed. key_cnt is not cleared by data writes.
- Reset mid-operation: all registers return to reset values immediately (async). No strobe is issued on reset release.

## Timing
- All outputs are registered. eng_start and eng_key_load are high for exactly one clk.
- host_wr (data) at cycle N -> state=ENC and eng_start=1 at N+1.
- Last key byte at N -> eng_key_load=1 at N+1 -> key_valid=1 and state IDLE at N+2. A data write is accepted from N+2.
- eng_done at cycle M -> dout/dout_valid updated at M+1.
- host_ack at cycle K in HOLD -> dout_valid=0 and state IDLE at K+1. The next host_wr is accepted at K+1.
- Timeout: with no eng_done, ERR and err_timeout=1 are reached TIMEOUT cycles after entering ENC.
- Minimum data-byte turnaround, assuming eng_done on the first ENC cycle and host_ack on the first HOLD cycle: 3 cycles.

## Test plan
- Reset with KEY_BYTES=4: write key bytes 0x11,0x22,0x33,0x44 -> eng_key=0x11223344, one eng_key_load pulse, key_valid=1.
- Data write 0xA5 with key loaded; engine returns 0x3C two cycles after eng_start -> eng_start pulses once, dout=0x3C, dout_valid stays high until host_ack, then clears.
- Data write before any key, and a data write during HOLD -> no eng_start, state and dout unchanged.
- Engine never asserts eng_done -> err_timeout=1 exactly TIMEOUT cycles after entering ENC. host_ack -> IDLE with key_valid still 1. eng_done at cycle TIMEOUT-1 -> dout captured, no error.
- Assert nrst low mid-ENC, and separately after 2 of 4 key bytes -> all outputs return to reset values. A new full 4-byte key is then required before key_valid=1.
